dataslot_cmd_arbiter: RTL and testbench
=======================================

// Module: dataslot_cmd_arbiter
// PURPOSE
//  Shares the single APF target_dataslot command port (read/write of slot data over the bridge) between
//  NUM_REQ requesters, e.g. the 832 MCU and a disk/floppy DMA engine. It selects one requester round-robin,
//  issues the command and tracks the ack/done handshake through 2-flop synchronisers. It then returns the
//  done status and error code to the requester that issued the command. Sits in clk_sys between the
//  requesters and the APF bridge.
// PARAMETERS
//  NUM_REQ      2         number of requesters (2..4)
//  TIMEOUT      28400000  clk_sys cycles allowed in WAIT_ACK plus WAIT_DONE before abort (~100 ms @ 284 MHz)
// PORTS
//  clk_sys                     in   1             system clock; the block's only clock
//  reset_n                     in   1             asynchronous active-low reset
//  req_valid                   in   NUM_REQ       per-requester command request, held until req_accept
//  req_write                   in   NUM_REQ       1 = slot write, 0 = slot read
//  req_id                      in   16*NUM_REQ    slot id, requester k at [16k+15:16k]
//  req_slotoffset              in   32*NUM_REQ    byte offset within the slot
//  req_bridgeaddr              in   32*NUM_REQ    bridge target address
//  req_length                  in   32*NUM_REQ    transfer length in bytes
//  req_accept                  out  NUM_REQ       one-hot 1-cycle pulse: command captured
//  req_done                    out  NUM_REQ       one-hot 1-cycle pulse: command finished
//  req_err                     out  3             error code, valid while req_done is high
//  busy                        out  1             high in any state other than IDLE
//  target_dataslot_read        out  1             read strobe to APF; the APF triggers on its rising edge
//  target_dataslot_write       out  1             write strobe to APF; the APF triggers on its rising edge
//  target_dataslot_ack         in   1             from clk_74a domain, asynchronous
//  target_dataslot_done        in   1             from clk_74a domain, asynchronous
//  target_dataslot_err         in   3             from clk_74a domain; sampled only when synced done is high
//  target_dataslot_id          out  16            registered command parameters
//  target_dataslot_slotoffset  out  32            registered command parameters
//  target_dataslot_bridgeaddr  out  32            registered command parameters
//  target_dataslot_length      out  32            registered command parameters
// BEHAVIOUR
//  - Reset: every output register is 0, the state is IDLE, the round-robin pointer is 0 and the timeout counter is 0.
//    The reset is asynchronous, so it also aborts an in-flight command. The read/write strobes drop at once
//    and no req_done is ever issued for the aborted command.
//  - Synchronisers: ack, done and err[2:0] each pass through 2 flops before any use. The synced values are
//    ack_s, done_s and err_s.
//  - Arbitration: round-robin. The search starts at the index after the last granted requester and wraps
//    from NUM_REQ-1 to 0. A requester is re-granted only if no other requester is valid.
//  - State IDLE -> ISSUE when any req_valid is high. On that same edge:
//      * latch the winner's id/offset/addr/length into target_dataslot_*,
//      * latch the winner's index and write flag,
//      * pulse req_accept[winner] for 1 cycle.
//    The latency from valid to accept is 1 cycle.
//  - ISSUE: drive target_dataslot_write = wflag and target_dataslot_read = ~wflag, then go to WAIT_ACK.
//    The parameters are stable at least 1 cycle before the strobe rises.
//  - WAIT_ACK: hold the strobe. When ack_s = 1, drop the strobe and go to WAIT_DONE. The strobe is
//    held until ack is seen because clk_sys is faster than clk_74a.
//  - WAIT_DONE: go to COMPLETE when ack_s = 0 and done_s = 1. Capture err_s on that edge.
//    A stale done from the previous command cannot complete early, because WAIT_ACK must pass first.
//  - COMPLETE (1 cycle): pulse req_done[owner], drive req_err = the captured err, advance the round-robin
//    pointer, then go to IDLE. A new grant can occur on the edge that leaves COMPLETE.
//  - Timeout: the counter clears in ISSUE and increments in WAIT_ACK and WAIT_DONE. When it reaches
//    TIMEOUT-1:
//      * drop both strobes,
//      * go to COMPLETE with req_err = 3'b111 (this value is reserved as the timeout code).
//  - The target_dataslot_* parameters hold their values after completion until the next grant.
//    Only one command is ever outstanding. req_valid changes while not in IDLE are ignored.
//  - When req_valid falls in the same cycle a grant would occur, the grant is still based on the
//    registered-edge sample. The requester must hold req_valid until it sees req_accept.
//  - target_dataslot_read and target_dataslot_write are never high together.
// TESTING
//  1. Single read: req 0 valid, id=16'h0003, len=32'h200. Expect accept[0] 1 cycle later and read rising
//     1 cycle after that. The bench raises ack after 10 clk_74a cycles, drops ack, then raises done with
//     err=0. Expect done[0] pulse with req_err = 0; the write strobe never rises.
//  2. Contention: req 0 and req 1 both valid continuously. Expect the grant order 0,1,0,1 over 4 commands,
//     and never two accepts between dones.
//  3. Stale done: done held high from a prior command and the new command issued. Expect no req_done
//     until the ack rise/fall is seen and then done is seen again.
//  4. Error pass-through: done with err=3'b010 on a write command. Expect req_err = 3'b010 with
//     req_done[1], and write (not read) asserted during WAIT_ACK.
//  5. Timeout: TIMEOUT=1000 and ack never asserted. Expect the strobe dropped and req_done with
//     req_err = 3'b111 exactly 1000 cycles after ISSUE, with busy falling on the next cycle.
//  6. Reset mid-command: assert reset_n low in WAIT_DONE. Expect all outputs 0 asynchronously, no
//     req_done, and a clean IDLE plus a new grant of requester 0 after release.

Source files
------------

// File: rtl/dataslot_cmd_arbiter.sv
`timescale 1ns/1ps
// dataslot_cmd_arbiter
//   Shares the single APF target_dataslot command port between NUM_REQ
//   requesters. One requester is picked round-robin, its command parameters
//   are registered, and the read or write strobe is held until the bridge
//   acknowledges. The done status and error code then go back to the
//   requester that issued the command. Only one command is outstanding at a time.
//
// Ports
//   clk_sys, reset_n            : system clock, asynchronous active-low reset
//   req_valid/req_write         : per-requester request and direction (1 = write)
//   req_id/slotoffset/...       : packed per-requester command parameters
//   req_accept/req_done         : one-hot single-cycle handshake pulses
//   req_err                     : error code, valid while req_done is high
//   busy                        : high in any state other than IDLE
//   target_dataslot_read/write  : command strobes to the APF bridge
//   target_dataslot_ack/done/err: asynchronous status from the clk_74a domain
//   target_dataslot_id/...      : registered command parameters
module dataslot_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 28400000
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [16*NUM_REQ-1:0]   req_id,
  input  logic [32*NUM_REQ-1:0]   req_slotoffset,
  input  logic [32*NUM_REQ-1:0]   req_bridgeaddr,
  input  logic [32*NUM_REQ-1:0]   req_length,
  output logic [NUM_REQ-1:0]      req_accept,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [2:0]              req_err,
  output logic                    busy,
  output logic                    target_dataslot_read,
  output logic                    target_dataslot_write,
  input  logic                    target_dataslot_ack,
  input  logic                    target_dataslot_done,
  input  logic [2:0]              target_dataslot_err,
  output logic [15:0]             target_dataslot_id,
  output logic [31:0]             target_dataslot_slotoffset,
  output logic [31:0]             target_dataslot_bridgeaddr,
  output logic [31:0]             target_dataslot_length
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE         = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [2:0]         ERR_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_COMPLETE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               wflag_q, wflag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] accept_q, accept_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [2:0]         err_q, err_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [15:0]        id_q, id_d;
  logic [31:0]        off_q, off_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        len_q, len_d;

  logic               ack_meta_q, ack_s;
  logic               done_meta_q, done_s;
  logic [2:0]         err_meta_q, err_s;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   search_start;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return ONE << i;
  endfunction

  // Two-flop synchronisers for the clk_74a-domain status signals.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta_q  <= 1'b0;
      ack_s       <= 1'b0;
      done_meta_q <= 1'b0;
      done_s      <= 1'b0;
      err_meta_q  <= 3'b000;
      err_s       <= 3'b000;
    end else begin
      ack_meta_q  <= target_dataslot_ack;
      ack_s       <= ack_meta_q;
      done_meta_q <= target_dataslot_done;
      done_s      <= done_meta_q;
      err_meta_q  <= target_dataslot_err;
      err_s       <= err_meta_q;
    end
  end

  // Round-robin search. In COMPLETE the pointer has not been advanced yet,
  // so the search starts after the current owner to allow a back-to-back grant.
  always_comb begin
    search_start = (state_q == S_COMPLETE) ? next_idx(owner_q) : ptr_q;
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand         = 0;
    cand_idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(search_start) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    wflag_d  = wflag_q;
    cnt_d    = cnt_q;
    accept_d = '0;
    done_d   = '0;
    err_d    = err_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    id_d     = id_q;
    off_d    = off_q;
    addr_d   = addr_q;
    len_d    = len_q;

    case (state_q)
      S_IDLE, S_COMPLETE: begin
        if (state_q == S_COMPLETE) ptr_d = next_idx(owner_q);
        state_d = S_IDLE;
        if (grant_found) begin
          state_d  = S_ISSUE;
          owner_d  = grant_idx;
          wflag_d  = req_write[grant_idx];
          id_d     = req_id[int'(grant_idx)*16 +: 16];
          off_d    = req_slotoffset[int'(grant_idx)*32 +: 32];
          addr_d   = req_bridgeaddr[int'(grant_idx)*32 +: 32];
          len_d    = req_length[int'(grant_idx)*32 +: 32];
          accept_d = onehot(grant_idx);
        end
      end
      // Parameters were registered on the previous edge, so they lead the strobe by a cycle.
      S_ISSUE: begin
        wr_d    = wflag_q;
        rd_d    = ~wflag_q;
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK, S_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = ERR_TIMEOUT;
          done_d  = onehot(owner_q);
          state_d = S_COMPLETE;
        end else if (state_q == S_WAIT_ACK) begin
          // clk_sys outruns clk_74a, so the strobe stays up until ack is seen.
          if (ack_s) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = S_WAIT_DONE;
          end
        end else if (!ack_s && done_s) begin
          err_d   = err_s;
          done_d  = onehot(owner_q);
          state_d = S_COMPLETE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      wflag_q  <= 1'b0;
      cnt_q    <= '0;
      accept_q <= '0;
      done_q   <= '0;
      err_q    <= 3'b000;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      id_q     <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      wflag_q  <= wflag_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      id_q     <= id_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
    end
  end

  assign req_accept                 = accept_q;
  assign req_done                   = done_q;
  assign req_err                    = err_q;
  assign busy                       = (state_q != S_IDLE);
  assign target_dataslot_read       = rd_q;
  assign target_dataslot_write      = wr_q;
  assign target_dataslot_id         = id_q;
  assign target_dataslot_slotoffset = off_q;
  assign target_dataslot_bridgeaddr = addr_q;
  assign target_dataslot_length     = len_q;

endmodule

// File: tb/tb_dataslot_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_dataslot_cmd_arbiter;

  logic        clk_sys = 1'b0;
  logic        clk_74a = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_write;
  logic [31:0] req_id;
  logic [63:0] req_slotoffset, req_bridgeaddr, req_length;
  logic [1:0]  req_accept, req_done;
  logic [2:0]  req_err;
  logic        busy, rd, wr;
  logic        ack, done;
  logic [2:0]  err;
  logic [15:0] t_id;
  logic [31:0] t_off, t_addr, t_len;

  always #5  clk_sys = ~clk_sys;
  always #13 clk_74a = ~clk_74a;

  dataslot_cmd_arbiter #(.NUM_REQ(2), .TIMEOUT(1000)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_id(req_id),
    .req_slotoffset(req_slotoffset), .req_bridgeaddr(req_bridgeaddr), .req_length(req_length),
    .req_accept(req_accept), .req_done(req_done), .req_err(req_err), .busy(busy),
    .target_dataslot_read(rd), .target_dataslot_write(wr),
    .target_dataslot_ack(ack), .target_dataslot_done(done), .target_dataslot_err(err),
    .target_dataslot_id(t_id), .target_dataslot_slotoffset(t_off),
    .target_dataslot_bridgeaddr(t_addr), .target_dataslot_length(t_len)
  );

  typedef struct {
    logic [1:0] valid;
    logic [1:0] write;
    logic [2:0] err;
    int         exp_g;
    logic       exp_w;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs [6];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   both_hi_cnt = 0;
  int   overlap_cnt = 0;
  logic outstanding = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  // Strobes exclusive, and at most one accepted command between dones.
  always @(negedge clk_sys) begin
    if (rd && wr) both_hi_cnt <= both_hi_cnt + 1;
    if (!reset_n) outstanding <= 1'b0;
    else begin
      if (|req_accept && outstanding) overlap_cnt <= overlap_cnt + 1;
      if (|req_done) outstanding <= 1'b0;
      else if (|req_accept) outstanding <= 1'b1;
    end
  end

  task automatic wait_strobe_drop(input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if (!rd && !wr) begin found = 1'b1; break; end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_done(input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_sys);
      if (|req_done) begin found = 1'b1; break; end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  // Called at a clk_sys negedge; returns at the negedge where req_done is seen.
  task automatic run_cmd(input vec_t v, input int n);
    req_valid = v.valid;
    req_write = v.write;
    @(negedge clk_sys);
    chk($sformatf("v%0d_accept", n), 32'(req_accept), 32'(oh(v.exp_g)));
    chk($sformatf("v%0d_id", n), 32'(t_id), (v.exp_g == 0) ? 32'h0003 : 32'h0007);
    chk($sformatf("v%0d_len", n), t_len, (v.exp_g == 0) ? 32'h200 : 32'h400);
    chk($sformatf("v%0d_addr", n), t_addr, (v.exp_g == 0) ? 32'h1000_0000 : 32'h2000_0000);
    req_valid[v.exp_g] = 1'b0;
    @(negedge clk_sys);
    chk($sformatf("v%0d_strobe", n), 32'({wr, rd}), v.exp_w ? 32'd2 : 32'd1);
    repeat (10) @(posedge clk_74a);
    chk($sformatf("v%0d_strobe_held", n), 32'({wr, rd}), v.exp_w ? 32'd2 : 32'd1);
    ack = 1'b1;
    wait_strobe_drop($sformatf("v%0d_ack_drop", n));
    ack = 1'b0;
    repeat (3) @(posedge clk_74a);
    err  = v.err;
    done = 1'b1;
    wait_done($sformatf("v%0d_done_seen", n));
    chk($sformatf("v%0d_done", n), 32'(req_done), 32'(oh(v.exp_g)));
    chk($sformatf("v%0d_err", n), 32'(req_err), 32'(v.exp_err));
    req_valid = 2'b00;
    done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int hit;

    vecs[0] = '{valid: 2'b01, write: 2'b00, err: 3'b000, exp_g: 0, exp_w: 1'b0, exp_err: 3'b000};
    vecs[1] = '{valid: 2'b10, write: 2'b10, err: 3'b010, exp_g: 1, exp_w: 1'b1, exp_err: 3'b010};
    vecs[2] = '{valid: 2'b11, write: 2'b10, err: 3'b001, exp_g: 0, exp_w: 1'b0, exp_err: 3'b001};
    vecs[3] = '{valid: 2'b11, write: 2'b10, err: 3'b100, exp_g: 1, exp_w: 1'b1, exp_err: 3'b100};
    vecs[4] = '{valid: 2'b11, write: 2'b10, err: 3'b000, exp_g: 0, exp_w: 1'b0, exp_err: 3'b000};
    vecs[5] = '{valid: 2'b11, write: 2'b10, err: 3'b101, exp_g: 1, exp_w: 1'b1, exp_err: 3'b101};

    reset_n = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_id = {16'h0007, 16'h0003};
    req_slotoffset = {32'h20, 32'h10};
    req_bridgeaddr = {32'h2000_0000, 32'h1000_0000};
    req_length = {32'h400, 32'h200};
    ack = 1'b0;
    done = 1'b0;
    err = 3'b000;

    repeat (3) @(negedge clk_sys);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({wr, rd}), 32'd0);
    chk("rst_accept_done", 32'({req_accept, req_done}), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    chk("rst_params", t_len | t_addr | t_off | 32'(t_id), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single read, write pass-through, then contention 0,1,0,1.
    for (int i = 0; i < 6; i++) run_cmd(vecs[i], i);

    // Stale done: done held high from command A must not complete command B.
    req_valid = 2'b01;
    req_write = 2'b00;
    @(negedge clk_sys);
    chk("stale_a_accept", 32'(req_accept), 32'd1);
    req_valid = 2'b00;
    repeat (4) @(posedge clk_74a);
    ack = 1'b1;
    wait_strobe_drop("stale_a_ack_drop");
    ack = 1'b0;
    repeat (3) @(posedge clk_74a);
    err = 3'b000;
    done = 1'b1;
    wait_done("stale_a_done_seen");
    chk("stale_a_done", 32'(req_done), 32'd1);
    @(negedge clk_sys);
    chk("stale_a_busy_fall", 32'(busy), 32'd0);
    req_valid = 2'b10;
    @(negedge clk_sys);
    chk("stale_b_accept", 32'(req_accept), 32'd2);
    req_valid = 2'b00;
    pulses = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (|req_done) pulses++;
    end
    chk("stale_no_done_before_ack", 32'(pulses), 32'd0);
    chk("stale_strobe_held", 32'(rd), 32'd1);
    ack = 1'b1;
    done = 1'b0;
    wait_strobe_drop("stale_b_ack_drop");
    ack = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (|req_done) pulses++;
    end
    chk("stale_no_done_before_new_done", 32'(pulses), 32'd0);
    err = 3'b011;
    done = 1'b1;
    wait_done("stale_b_done_seen");
    chk("stale_b_done", 32'(req_done), 32'd2);
    chk("stale_b_err", 32'(req_err), 32'd3);
    done = 1'b0;

    // Timeout: ack never arrives.
    req_valid = 2'b01;
    @(negedge clk_sys);
    chk("to_accept", 32'(req_accept), 32'd1);
    req_valid = 2'b00;
    @(negedge clk_sys);
    chk("to_strobe_rise", 32'(rd), 32'd1);
    hit = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk_sys);
      if (k == 999) chk("to_strobe_before_expiry", 32'(rd), 32'd1);
      if (|req_done) begin hit = k; break; end
    end
    chk("to_latency", 32'(hit), 32'd1000);
    chk("to_strobe_dropped", 32'({wr, rd}), 32'd0);
    chk("to_done", 32'(req_done), 32'd1);
    chk("to_err", 32'(req_err), 32'd7);
    chk("to_busy_high", 32'(busy), 32'd1);
    @(negedge clk_sys);
    chk("to_busy_fall", 32'(busy), 32'd0);

    // Reset in WAIT_DONE.
    req_valid = 2'b01;
    @(negedge clk_sys);
    chk("rm_accept", 32'(req_accept), 32'd1);
    req_valid = 2'b00;
    repeat (4) @(posedge clk_74a);
    ack = 1'b1;
    wait_strobe_drop("rm_ack_drop");
    ack = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("rm_busy_wait_done", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_async_busy", 32'(busy), 32'd0);
    chk("rm_async_outs", 32'({wr, rd, req_accept, req_done, req_err}), 32'd0);
    chk("rm_async_params", t_len | t_addr | 32'(t_id), 32'd0);
    done = 1'b1;
    err = 3'b101;
    req_valid = 2'b11;
    repeat (3) @(negedge clk_sys);
    chk("rm_no_done_in_reset", 32'(req_done), 32'd0);
    done = 1'b0;
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("rm_regrant_0", 32'(req_accept), 32'd1);
    chk("rm_no_done_after", 32'(req_done), 32'd0);
    req_valid = 2'b10;
    @(negedge clk_sys);
    chk("rm_new_read", 32'({wr, rd}), 32'd1);
    req_valid = 2'b00;

    chk("strobes_exclusive", 32'(both_hi_cnt), 32'd0);
    chk("one_outstanding", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
